// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, GF(2^8) constants, sequencer state codes,
// and the byte-level S-box / xtime helpers used by the round datapath.
package aes_pkg;

    localparam int unsigned NR_AES256 = 14;
    localparam logic [7:0]  GF_POLY   = 8'h1B;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES encryption round: SubBytes, ShiftRows, column mix (skipped on
// the final round) and AddRoundKey. Byte i of the state sits at [127-8i -: 8].
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte index = 4*column + row; ShiftRows rotates row r left by r columns
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign sb[i] = sbox(state_in[127-8*i -: 8]);
        assign sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
        assign state_out[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*c];
        assign a1 = sr[4*c+1];
        assign a2 = sr[4*c+2];
        assign a3 = sr[4*c+3];
        assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes256_round_sequencer.sv
// Iterative AES-256 encryptor: one shared round per clock over a 128-bit state register,
// round keys fetched by index from an external store, ciphertext on a valid/ready port.
module aes256_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_o
);

    logic [1:0]   state;
    logic [3:0]   round;
    logic [127:0] state_reg;
    logic [127:0] round_out;
    logic         accept;
    logic         last;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (round == 4'(NR));
    assign key_idx   = (state == ST_ROUND) ? round : 4'd0;
    assign out_valid = (state == ST_DONE);
    assign out_data  = state_reg;
    assign busy      = (state == ST_ROUND);
    assign round_o   = round;

    aes_round_unit u_round (
        .state_in  (state_reg),
        .rk        (key_rk),
        .last      (last),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            round     <= '0;
            state_reg <= '0;
        end else begin
            case (state)
                // DONE shares the load path so a pop and a new accept share one edge
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_reg <= in_data ^ key_rk;
                        round     <= 4'd1;
                        state     <= ST_ROUND;
                    end else if ((state == ST_DONE) && out_ready) begin
                        round <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    if (last) state <= ST_DONE;
                    else      round <= round + 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
